mem_rr_arbiter: RTL and testbench



---
 rtl/mem_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter that owns the memory port and runs one
// access at a time, returning read data and a one-cycle ACK to the winner.
module mem_rr_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WR_RDbar0,
    input  logic              WR_RDbar1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              ACK0,
    output logic              ACK1,
    output logic              ERR0,
    output logic              ERR1,
    output logic [DATA_W-1:0] RDATA0,
    output logic [DATA_W-1:0] RDATA1,
    output logic              SEL,
    output logic              WR_RDbar,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] WDATA,
    input  logic              READY,
    input  logic [DATA_W-1:0] RDATA,
    output logic              BUSY
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q;
    logic                last_q;
    logic                win_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                sel_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                ack0_q, ack1_q;
    logic                err0_q, err1_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;
    logic                busy_q;

    logic                win_d;
    logic                wr_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

    // Requester 1 wins when it is alone, or when both ask and 0 was served last.
    always_comb begin
        win_d   = REQ1 && (!REQ0 || !last_q);
        wr_d    = win_d ? WR_RDbar1 : WR_RDbar0;
        addr_d  = win_d ? ADDR1 : ADDR0;
        wdata_d = win_d ? WDATA1 : WDATA0;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (REQ0 || REQ1) begin
                        win_q   <= win_d;
                        last_q  <= win_d;
                        wr_q    <= wr_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        sel_q   <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (READY) begin
                        if (!wr_q) begin
                            if (win_q) rdata1_q <= RDATA;
                            else       rdata0_q <= RDATA;
                        end
                        sel_q   <= 1'b0;
                        ack0_q  <= !win_q;
                        ack1_q  <= win_q;
                        state_q <= RESP;
                    end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                        // Give up: the requester sees ACK with ERR, read data untouched.
                        sel_q   <= 1'b0;
                        ack0_q  <= !win_q;
                        ack1_q  <= win_q;
                        err0_q  <= !win_q;
                        err1_q  <= win_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    sel_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ACK0     = ack0_q;
    assign ACK1     = ack1_q;
    assign ERR0     = err0_q;
    assign ERR1     = err1_q;
    assign RDATA0   = rdata0_q;
    assign RDATA1   = rdata1_q;
    assign SEL      = sel_q;
    assign WR_RDbar = wr_q;
    assign ADDR     = addr_q;
    assign WDATA    = wdata_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model of arbitration, memory and timing.
module tb_mem_rr_arbiter;

    logic        clk = 1'b0;
    logic        RST;
    logic        REQ0, REQ1, WR_RDbar0, WR_RDbar1;
    logic [7:0]  ADDR0, ADDR1;
    logic [15:0] WDATA0, WDATA1;
    logic        ACK0, ACK1, ERR0, ERR1;
    logic [15:0] RDATA0, RDATA1;
    logic        SEL, WR_RDbar;
    logic [7:0]  ADDR;
    logic [15:0] WDATA;
    logic        READY;
    logic [15:0] RDATA;
    logic        BUSY;

    int errors = 0;
    int checks = 0;

    // Memory responder controls: READY in the Nth SEL-high cycle, 0 = never.
    int   rdy_delay = 0;
    logic spurious  = 1'b0;
    logic mem_clr   = 1'b0;
    int   sel_cyc   = 0;
    logic [15:0] mem [256];

    mem_rr_arbiter #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1),
        .WR_RDbar0(WR_RDbar0), .WR_RDbar1(WR_RDbar1),
        .ADDR0(ADDR0), .ADDR1(ADDR1),
        .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1), .ERR0(ERR0), .ERR1(ERR1),
        .RDATA0(RDATA0), .RDATA1(RDATA1),
        .SEL(SEL), .WR_RDbar(WR_RDbar), .ADDR(ADDR), .WDATA(WDATA),
        .READY(READY), .RDATA(RDATA), .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'(i * 37 + 5);
        end
        RDATA = 16'($urandom);
        if (SEL) begin
            sel_cyc = sel_cyc + 1;
            if (rdy_delay > 0 && sel_cyc == rdy_delay) begin
                READY = 1'b1;
                if (WR_RDbar) mem[ADDR] = WDATA;
                else          RDATA = mem[ADDR];
            end else begin
                READY = 1'b0;
            end
        end else begin
            sel_cyc = 0;
            READY   = spurious;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs until an ACK appears; reports who, cycles from first edge to ACK, and SEL-high cycles.
    task automatic wait_ack(output int who, output int n, output int s);
        who = -1; n = 0; s = 0;
        while (who < 0 && n < 60) begin
            tick;
            n++;
            if (SEL) s++;
            if (ACK0 || ACK1) who = ACK1 ? 1 : 0;
        end
        chk("ack_seen", 32'(who >= 0), 32'(1));
        chk("ack_exclusive", 32'(ACK0 && ACK1), 32'(0));
    endtask

    task automatic idle_gap;
        tick;
        chk("gap_busy", 32'(BUSY), 32'(0));
        chk("gap_ack", 32'({ACK0, ACK1, ERR0, ERR1}), 32'(0));
    endtask

    int who, n, s, w, d;
    int order [4];
    int mlast;
    logic [15:0] ref_mem [256];
    logic [15:0] exp_rd [2];
    logic        pend [2];
    logic        c_wr [2];
    logic [7:0]  c_addr [2];
    logic [15:0] c_wd [2];

    initial begin
        RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; WR_RDbar0 = 1'b0; WR_RDbar1 = 1'b0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
        mem_clr = 1'b1;
        repeat (3) tick;
        mem_clr = 1'b0;
        chk("rst_sel_wr", 32'({SEL, WR_RDbar}), 32'(0));
        chk("rst_busy", 32'(BUSY), 32'(0));
        chk("rst_ack_err", 32'({ACK0, ACK1, ERR0, ERR1}), 32'(0));
        chk("rst_rdata", 32'({RDATA0, RDATA1}), 32'(0));
        chk("rst_addr_wdata", 32'({ADDR, WDATA}), 32'(0));
        RST = 1'b0;

        // Single write, READY on the second ACCESS cycle
        REQ0 = 1'b1; WR_RDbar0 = 1'b1; ADDR0 = 8'h12; WDATA0 = 16'hA5A5; rdy_delay = 2;
        tick;
        chk("wr_sel", 32'(SEL), 32'(1));
        chk("wr_cmd", 32'({WR_RDbar, ADDR, WDATA}), 32'({1'b1, 8'h12, 16'hA5A5}));
        chk("wr_busy", 32'(BUSY), 32'(1));
        wait_ack(who, n, s);
        REQ0 = 1'b0;
        chk("wr_who", 32'(who), 32'(0));
        chk("wr_sel_cycles", 32'(s + 1), 32'(2));
        chk("wr_latency", 32'(n + 1), 32'(3));
        chk("wr_err_rdata", 32'({ERR0, RDATA0}), 32'(0));
        chk("wr_resp_sel", 32'({SEL, BUSY}), 32'({1'b0, 1'b1}));
        idle_gap;

        // Read by requester 1, READY on the first ACCESS edge
        REQ1 = 1'b1; WR_RDbar1 = 1'b0; ADDR1 = 8'h12; rdy_delay = 1;
        wait_ack(who, n, s);
        REQ1 = 1'b0;
        chk("rd_who", 32'(who), 32'(1));
        chk("rd_latency", 32'(n), 32'(2));
        chk("rd_sel_cycles", 32'(s), 32'(1));
        chk("rd_rdata1", 32'(RDATA1), 32'(16'hA5A5));
        chk("rd_err", 32'(ERR1), 32'(0));
        idle_gap;

        // Read by requester 0 to give RDATA0 a non-zero value
        REQ0 = 1'b1; WR_RDbar0 = 1'b0; ADDR0 = 8'h12; rdy_delay = 3;
        wait_ack(who, n, s);
        REQ0 = 1'b0;
        chk("rd0_who", 32'(who), 32'(0));
        chk("rd0_latency", 32'(n), 32'(4));
        chk("rd0_rdata0", 32'(RDATA0), 32'(16'hA5A5));
        idle_gap;

        // Timeout: READY never comes
        REQ0 = 1'b1; WR_RDbar0 = 1'b0; ADDR0 = 8'h34; rdy_delay = 0;
        wait_ack(who, n, s);
        REQ0 = 1'b0;
        chk("to_who", 32'(who), 32'(0));
        chk("to_sel_cycles", 32'(s), 32'(15));
        chk("to_err", 32'({ACK0, ERR0}), 32'(2'b11));
        chk("to_rdata0", 32'(RDATA0), 32'(16'hA5A5));
        idle_gap;

        REQ0 = 1'b1; WR_RDbar0 = 1'b1; ADDR0 = 8'h34; WDATA0 = 16'h1234; rdy_delay = 1;
        wait_ack(who, n, s);
        REQ0 = 1'b0;
        chk("post_to_who", 32'(who), 32'(0));
        chk("post_to_ok", 32'({n, 1'b0, ERR0}), 32'({32'd2, 2'b00}));
        idle_gap;

        // Reset in the third ACCESS cycle of a requester-1 read
        REQ1 = 1'b1; WR_RDbar1 = 1'b0; ADDR1 = 8'h12; rdy_delay = 0;
        repeat (3) tick;
        chk("mid_sel_before", 32'(SEL), 32'(1));
        RST = 1'b1;
        tick;
        RST = 1'b0;
        chk("mid_sel", 32'(SEL), 32'(0));
        chk("mid_busy", 32'(BUSY), 32'(0));
        chk("mid_ack", 32'({ACK0, ACK1, ERR0, ERR1}), 32'(0));
        chk("mid_rdata", 32'({RDATA0, RDATA1}), 32'(0));

        // Both requesters held: 0 first after reset, then strict alternation
        REQ0 = 1'b1; WR_RDbar0 = 1'b0; ADDR0 = 8'h12; rdy_delay = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(who, n, s);
            order[k] = who;
            if (k == 3) begin
                REQ0 = 1'b0; REQ1 = 1'b0;
            end
            idle_gap;
        end
        chk("cont_order", 32'({order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0]}),
            32'(16'h0101));

        // READY pulses while idle must be ignored
        spurious = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("spur_state", 32'({SEL, BUSY, ACK0, ACK1}), 32'(0));
        end
        spurious = 1'b0;

        // Randomized traffic against the transaction model
        RST = 1'b1; mem_clr = 1'b1;
        tick;
        RST = 1'b0; mem_clr = 1'b0;
        tick;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 37 + 5);
        exp_rd[0] = '0; exp_rd[1] = '0;
        mlast = 1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1;
                    c_wr[r] = 1'($urandom_range(0, 1));
                    c_addr[r] = 8'($urandom_range(0, 15));
                    c_wd[r] = 16'($urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                w = int'($urandom_range(0, 1));
                pend[w] = 1'b1;
                c_wr[w] = 1'($urandom_range(0, 1));
                c_addr[w] = 8'($urandom_range(0, 15));
                c_wd[w] = 16'($urandom);
            end
            REQ0 = pend[0]; WR_RDbar0 = c_wr[0]; ADDR0 = c_addr[0]; WDATA0 = c_wd[0];
            REQ1 = pend[1]; WR_RDbar1 = c_wr[1]; ADDR1 = c_addr[1]; WDATA1 = c_wd[1];
            w = (pend[0] && pend[1]) ? 1 - mlast : (pend[1] ? 1 : 0);
            d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            rdy_delay = d;
            wait_ack(who, n, s);
            chk("rnd_who", 32'(who), 32'(w));
            chk("rnd_latency", 32'(n), 32'((d == 0) ? 16 : d + 1));
            chk("rnd_sel_cycles", 32'(s), 32'((d == 0) ? 15 : d));
            chk("rnd_err", 32'((w == 0) ? ERR0 : ERR1), 32'(d == 0));
            if (d != 0) begin
                if (c_wr[w]) ref_mem[c_addr[w]] = c_wd[w];
                else         exp_rd[w] = ref_mem[c_addr[w]];
            end
            chk("rnd_rdata0", 32'(RDATA0), 32'(exp_rd[0]));
            chk("rnd_rdata1", 32'(RDATA1), 32'(exp_rd[1]));
            mlast = w;
            pend[w] = 1'b0;
            if (w == 0) REQ0 = 1'b0;
            else        REQ1 = 1'b0;
            idle_gap;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
